// File: rtl/sy_pkg.sv
// Shared pipeline definitions: register/data widths, writeback request record
// and requester indices used by the writeback arbiter.
package sy_pkg;

  localparam int unsigned PHY_REG_WTH = 6;
  localparam int unsigned DWTH        = 32;

  localparam int unsigned WB_REQ_ALU = 0;
  localparam int unsigned WB_REQ_CSR = 1;
  localparam int unsigned WB_REQ_LSU = 2;
  localparam int unsigned WB_REQ_MDU = 3;
  localparam int unsigned WB_REQ_FPU = 4;

  typedef struct packed {
    logic                   en;
    logic [PHY_REG_WTH-1:0] idx;
    logic [DWTH-1:0]        data;
  } wb_req_t;

endpackage

// File: rtl/sy_ppl_wb_rr_sel.sv
// Combinational round-robin writeback grant selector: scans requesters
// circularly from rr_ptr and assigns up to WB_PORT conflict-free grants.
module sy_ppl_wb_rr_sel #(
  parameter int unsigned REQ_NUM     = 5,
  parameter int unsigned WB_PORT     = 2,
  parameter int unsigned PHY_REG_WTH = 6,
  parameter int unsigned PTR_W       = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic [REQ_NUM-1:0]     valid,
  input  logic [PHY_REG_WTH-1:0] idx [REQ_NUM],
  input  logic [PTR_W-1:0]       rr_ptr,
  output logic [REQ_NUM-1:0]     grant,
  output logic [WB_PORT-1:0]     port_vld,
  output logic [PTR_W-1:0]       port_sel [WB_PORT],
  output logic [PTR_W-1:0]       last
);

  int unsigned            r;
  int unsigned            used;
  logic                   v_r;
  logic                   hit;
  logic [PHY_REG_WTH-1:0] idx_r;

  always_comb begin
    grant    = '0;
    port_vld = '0;
    last     = '0;
    r        = 0;
    used     = 0;
    v_r      = 1'b0;
    hit      = 1'b0;
    idx_r    = '0;
    for (int unsigned k = 0; k < WB_PORT; k++) port_sel[k] = '0;

    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      r = 32'(rr_ptr) + i;
      if (r >= REQ_NUM) r = r - REQ_NUM;

      v_r   = 1'b0;
      idx_r = '0;
      for (int unsigned j = 0; j < REQ_NUM; j++) begin
        if (j == r) begin
          v_r   = valid[j];
          idx_r = idx[j];
        end
      end

      // x0 never conflicts; any other idx already granted this cycle blocks.
      hit = 1'b0;
      for (int unsigned j = 0; j < REQ_NUM; j++) begin
        if (grant[j] && (idx[j] == idx_r) && (idx_r != '0)) hit = 1'b1;
      end

      if (v_r && (used < WB_PORT) && !hit) begin
        for (int unsigned j = 0; j < REQ_NUM; j++) begin
          if (j == r) grant[j] = 1'b1;
        end
        for (int unsigned k = 0; k < WB_PORT; k++) begin
          if (k == used) begin
            port_vld[k] = 1'b1;
            port_sel[k] = PTR_W'(r);
          end
        end
        last = PTR_W'(r);
        used = used + 1;
      end
    end
  end

endmodule

// File: rtl/sy_ppl_wb_arb.sv
// Writeback arbiter sharing WB_PORT GPR write ports among REQ_NUM result
// requesters. Optional stall counter enabled by SY_WB_ARB_PERF_EN.
module sy_ppl_wb_arb
  import sy_pkg::*;
#(
  parameter int unsigned REQ_NUM     = 5,
  parameter int unsigned WB_PORT     = 2,
  parameter int unsigned PHY_REG_WTH = sy_pkg::PHY_REG_WTH,
  parameter int unsigned DWTH        = sy_pkg::DWTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [REQ_NUM-1:0]     req_valid_i,
  input  logic [PHY_REG_WTH-1:0] req_idx_i  [REQ_NUM],
  input  logic [DWTH-1:0]        req_data_i [REQ_NUM],
  output logic [REQ_NUM-1:0]     req_ready_o,
  output logic [WB_PORT-1:0]     wb_en_o,
  output logic [PHY_REG_WTH-1:0] wb_idx_o  [WB_PORT],
  output logic [DWTH-1:0]        wb_data_o [WB_PORT]
`ifdef SY_WB_ARB_PERF_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [PTR_W-1:0]       rr_ptr;
  logic [REQ_NUM-1:0]     grant;
  logic [WB_PORT-1:0]     port_vld;
  logic [PTR_W-1:0]       port_sel [WB_PORT];
  logic [PTR_W-1:0]       last;
  logic [PHY_REG_WTH-1:0] sel_idx  [WB_PORT];
  logic [DWTH-1:0]        sel_data [WB_PORT];

  sy_ppl_wb_rr_sel #(
    .REQ_NUM     (REQ_NUM),
    .WB_PORT     (WB_PORT),
    .PHY_REG_WTH (PHY_REG_WTH),
    .PTR_W       (PTR_W)
  ) u_sel (
    .valid    (req_valid_i),
    .idx      (req_idx_i),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .port_vld (port_vld),
    .port_sel (port_sel),
    .last     (last)
  );

  assign req_ready_o = rst_i ? '0 : grant;

  always_comb begin
    for (int unsigned k = 0; k < WB_PORT; k++) begin
      sel_idx[k]  = '0;
      sel_data[k] = '0;
      for (int unsigned j = 0; j < REQ_NUM; j++) begin
        if (PTR_W'(j) == port_sel[k]) begin
          sel_idx[k]  = req_idx_i[j];
          sel_data[k] = req_data_i[j];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      wb_en_o <= '0;
      for (int unsigned k = 0; k < WB_PORT; k++) begin
        wb_idx_o[k]  <= '0;
        wb_data_o[k] <= '0;
      end
    end else begin
      if (|grant) rr_ptr <= (last == PTR_W'(REQ_NUM - 1)) ? '0 : last + 1'b1;
      for (int unsigned k = 0; k < WB_PORT; k++) begin
        // x0 grants still consume the port, but the write itself is dropped.
        wb_en_o[k] <= port_vld[k] && (sel_idx[k] != '0);
        if (port_vld[k]) begin
          wb_idx_o[k]  <= sel_idx[k];
          wb_data_o[k] <= sel_data[k];
        end
      end
    end
  end

`ifdef SY_WB_ARB_PERF_EN
  logic stall;
  assign stall = |(req_valid_i & ~grant);

  always_ff @(posedge clk_i) begin
    if (rst_i)                          stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule
